// File: rtl/noc_flit_if_packet_demux.sv
`default_nettype none
// ============================================================================
// Module  : noc_flit_if_packet_demux
// Brief   : Packet-aware flit demux; per-VC route held from head to tail flit.
// Revision: 1.0
// ============================================================================
module noc_flit_if_packet_demux #(
    parameter int CHANNELS   = 2,
    parameter int ENTRIES    = 2,
    parameter int REGISTERED = 1,
    parameter int FLIT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*ENTRIES-1:0]    i_select,
    input  logic [CHANNELS-1:0]            i_in_valid,
    output logic [CHANNELS-1:0]            o_in_ready,
    input  logic [FLIT_WIDTH-1:0]          i_in_flit,
    output logic [CHANNELS-1:0]            o_in_vc_available,
    output logic [ENTRIES*CHANNELS-1:0]    o_out_valid,
    input  logic [ENTRIES*CHANNELS-1:0]    i_out_ready,
    output logic [ENTRIES*FLIT_WIDTH-1:0]  o_out_flit,
    input  logic [ENTRIES*CHANNELS-1:0]    i_out_vc_available,
    output logic [CHANNELS-1:0]            o_error
);

    localparam int c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state [CHANNELS];
    logic [c_IDX_W-1:0]   r_route [CHANNELS];
    logic [CHANNELS-1:0]  r_error;

    logic                 w_head;
    logic                 w_tail;
    logic [CHANNELS-1:0]  w_sel_any;
    logic [c_IDX_W-1:0]   w_sel_idx   [CHANNELS];
    logic [c_IDX_W-1:0]   w_route_idx [CHANNELS];
    logic [CHANNELS-1:0]  w_drop;
    logic [CHANNELS-1:0]  w_in_ready;
    logic [CHANNELS-1:0]  w_accept;
    logic [CHANNELS-1:0]  w_vc_avail;
    logic [CHANNELS-1:0]  w_steer     [ENTRIES];
    logic [ENTRIES*CHANNELS-1:0] w_path_ready;

    assign w_head = i_in_flit[FLIT_WIDTH-1];
    assign w_tail = i_in_flit[FLIT_WIDTH-2];

    // Lowest set select bit wins when the request is multi-hot.
    always_comb begin
        for (int vc = 0; vc < CHANNELS; vc++) begin
            w_sel_any[vc] = 1'b0;
            w_sel_idx[vc] = '0;
            for (int e = ENTRIES - 1; e >= 0; e--) begin
                if (i_select[vc*ENTRIES + e]) begin
                    w_sel_any[vc] = 1'b1;
                    w_sel_idx[vc] = c_IDX_W'(e);
                end
            end
        end
    end

    always_comb begin
        for (int vc = 0; vc < CHANNELS; vc++) begin
            if (r_state[vc] == ST_BUSY) begin
                w_route_idx[vc] = r_route[vc];
                w_drop[vc]      = 1'b0;
                w_vc_avail[vc]  = i_out_vc_available[int'(r_route[vc])*CHANNELS + vc];
            end else begin
                w_route_idx[vc] = w_sel_idx[vc];
                w_drop[vc]      = !(w_head && w_sel_any[vc]);
                w_vc_avail[vc]  = w_sel_any[vc] &&
                                  i_out_vc_available[int'(w_sel_idx[vc])*CHANNELS + vc];
            end
            if (rst)
                w_in_ready[vc] = 1'b0;
            else if (w_drop[vc])
                w_in_ready[vc] = 1'b1;
            else
                w_in_ready[vc] = w_path_ready[int'(w_route_idx[vc])*CHANNELS + vc];
            w_accept[vc] = i_in_valid[vc] && w_in_ready[vc];
        end
        for (int e = 0; e < ENTRIES; e++) begin
            w_steer[e] = '0;
            for (int vc = 0; vc < CHANNELS; vc++) begin
                w_steer[e][vc] = i_in_valid[vc] && !w_drop[vc] &&
                                 (w_route_idx[vc] == c_IDX_W'(e));
            end
        end
    end

    assign o_in_ready        = w_in_ready;
    assign o_in_vc_available = w_vc_avail;
    assign o_error           = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= '0;
            for (int vc = 0; vc < CHANNELS; vc++) begin
                r_state[vc] <= ST_IDLE;
                r_route[vc] <= '0;
            end
        end else begin
            r_error <= w_accept & w_drop;
            for (int vc = 0; vc < CHANNELS; vc++) begin
                if (w_accept[vc] && !w_drop[vc]) begin
                    case (r_state[vc])
                        ST_IDLE: begin
                            if (w_head && !w_tail) begin
                                r_state[vc] <= ST_BUSY;
                                r_route[vc] <= w_sel_idx[vc];
                            end
                        end
                        ST_BUSY: begin
                            // A stray head inside a packet is carried as body.
                            if (w_tail)
                                r_state[vc] <= ST_IDLE;
                        end
                        default: r_state[vc] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    generate
        if (REGISTERED != 0) begin : g_registered
            for (genvar e = 0; e < ENTRIES; e++) begin : g_slice
                logic [CHANNELS-1:0]   r_sv;
                logic [FLIT_WIDTH-1:0] r_sf;
                logic [CHANNELS-1:0]   w_load_vc;
                logic                  w_drain;
                logic                  w_can_load;

                assign w_load_vc  = w_steer[e] & w_in_ready;
                assign w_drain    = |(r_sv & i_out_ready[e*CHANNELS +: CHANNELS]);
                assign w_can_load = !(|r_sv) || w_drain;
                assign w_path_ready[e*CHANNELS +: CHANNELS] = {CHANNELS{w_can_load}};
                assign o_out_valid[e*CHANNELS +: CHANNELS]  = r_sv;
                assign o_out_flit[e*FLIT_WIDTH +: FLIT_WIDTH] = r_sf;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sv <= '0;
                        r_sf <= '0;
                    end else if (|w_load_vc) begin
                        r_sv <= w_load_vc;
                        r_sf <= i_in_flit;
                    end else if (w_drain) begin
                        r_sv <= '0;
                    end
                end
            end
        end else begin : g_combinational
            for (genvar e = 0; e < ENTRIES; e++) begin : g_path
                assign w_path_ready[e*CHANNELS +: CHANNELS] = i_out_ready[e*CHANNELS +: CHANNELS];
                assign o_out_valid[e*CHANNELS +: CHANNELS]  = rst ? '0 : w_steer[e];
                assign o_out_flit[e*FLIT_WIDTH +: FLIT_WIDTH] = i_in_flit;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_if_packet_demux.sv
`default_nettype none
// Bench for noc_flit_if_packet_demux (REGISTERED=1, 2 VCs, 2 outputs):
// directed packet scenarios plus a randomized run against a behavioural model.
module tb_noc_flit_if_packet_demux;
    localparam int CH = 2;
    localparam int E  = 2;
    localparam int FW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*E-1:0]   sel;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [FW-1:0]     in_flit;
    logic [CH-1:0]     in_avail;
    logic [E*CH-1:0]   out_valid;
    logic [E*CH-1:0]   out_ready;
    logic [E*FW-1:0]   out_flit;
    logic [E*CH-1:0]   out_avail;
    logic [CH-1:0]     error;

    noc_flit_if_packet_demux #(
        .CHANNELS(CH), .ENTRIES(E), .REGISTERED(1), .FLIT_WIDTH(FW)
    ) dut (
        .clk(clk), .rst(rst), .i_select(sel),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_flit(in_flit),
        .o_in_vc_available(in_avail),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_flit(out_flit),
        .i_out_vc_available(out_avail), .o_error(error)
    );

    always #5 clk = ~clk;

    // Model: per-VC packet state and per-output one-deep slot.
    bit             m_busy [CH];
    int             m_route[CH];
    bit             m_err  [CH];
    bit             m_sv   [E];
    int             m_svc  [E];
    logic [FW-1:0]  m_sf   [E];
    bit             n_busy [CH];
    int             n_route[CH];
    bit             n_err  [CH];
    bit             n_sv   [E];
    int             n_svc  [E];
    logic [FW-1:0]  n_sf   [E];
    bit             m_stalled;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [13:0] p);
        return {h, t, p};
    endfunction

    function automatic int lowest(input int v);
        for (int e = 0; e < E; e++)
            if (sel[v*E + e]) return e;
        return -1;
    endfunction

    task automatic reset_model();
        for (int v = 0; v < CH; v++) begin
            m_busy[v] = 0; m_route[v] = 0; m_err[v] = 0;
        end
        for (int e = 0; e < E; e++) begin
            m_sv[e] = 0; m_svc[e] = 0; m_sf[e] = '0;
        end
        m_stalled = 0;
    endtask

    // Evaluate the pre-edge cycle from the rules and check the combinational outputs.
    task automatic predict();
        bit head;
        head = in_flit[FW-1];
        m_stalled = 0;
        for (int v = 0; v < CH; v++) begin
            n_busy[v] = m_busy[v]; n_route[v] = m_route[v]; n_err[v] = 0;
        end
        for (int e = 0; e < E; e++) begin
            n_sv[e]  = m_sv[e] && !out_ready[e*CH + m_svc[e]];
            n_svc[e] = m_svc[e];
            n_sf[e]  = m_sf[e];
        end
        for (int v = 0; v < CH; v++) begin
            int  r, lo;
            bit  rdy, av;
            lo = lowest(v);
            if (m_busy[v])            r = m_route[v];
            else if (head && lo >= 0) r = lo;
            else                      r = -1;
            rdy = (r < 0) ? 1'b1 : (!m_sv[r] || out_ready[r*CH + m_svc[r]]);
            if (m_busy[v])   av = out_avail[m_route[v]*CH + v];
            else if (lo >= 0) av = out_avail[lo*CH + v];
            else             av = 1'b0;
            check($sformatf("vc_avail[%0d]", v), in_avail[v], av);
            if (in_valid[v]) begin
                check($sformatf("in_ready[%0d]", v), in_ready[v], rdy);
                if (!rdy) m_stalled = 1;
                if (rdy && r < 0) n_err[v] = 1;
                if (rdy && r >= 0) begin
                    n_sv[r] = 1; n_svc[r] = v; n_sf[r] = in_flit;
                    if (!m_busy[v] && head && !in_flit[FW-2]) begin
                        n_busy[v] = 1; n_route[v] = r;
                    end else if (m_busy[v] && in_flit[FW-2]) begin
                        n_busy[v] = 0;
                    end
                end
            end
        end
    endtask

    // One clock: predict, step the edge, then compare registered outputs.
    task automatic cycle();
        #1;
        predict();
        @(posedge clk);
        #1;
        for (int v = 0; v < CH; v++) begin
            m_busy[v] = n_busy[v]; m_route[v] = n_route[v]; m_err[v] = n_err[v];
        end
        for (int e = 0; e < E; e++) begin
            m_sv[e] = n_sv[e]; m_svc[e] = n_svc[e]; m_sf[e] = n_sf[e];
        end
        for (int e = 0; e < E; e++) begin
            for (int v = 0; v < CH; v++)
                check($sformatf("out_valid[%0d][%0d]", e, v), out_valid[e*CH + v],
                      m_sv[e] && (m_svc[e] == v));
            if (m_sv[e])
                check($sformatf("out_flit[%0d]", e), out_flit[e*FW +: FW], m_sf[e]);
        end
        for (int v = 0; v < CH; v++)
            check($sformatf("error[%0d]", v), error[v], m_err[v]);
    endtask

    task automatic drive(input int v, input logic [E-1:0] s, input logic [FW-1:0] f);
        in_valid = '0;
        in_valid[v] = 1'b1;
        sel[v*E +: E] = s;
        in_flit = f;
    endtask

    logic [FW-1:0] pkt [4];

    initial begin
        rst = 1'b1; sel = '0; in_valid = '0; in_flit = '0;
        out_ready = '1; out_avail = '1;
        reset_model();
        #2;
        check("reset out_valid", out_valid, '0);
        check("reset in_ready", in_ready, '0);
        check("reset error", error, '0);
        @(negedge clk);
        rst = 1'b0;

        // Four-flit packet on VC0 to out0, visible one cycle after each accept.
        pkt[0] = mk(1, 0, 14'h0011); pkt[1] = mk(0, 0, 14'h0022);
        pkt[2] = mk(0, 0, 14'h0033); pkt[3] = mk(0, 1, 14'h0044);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b01, pkt[i]);
            cycle();
            check("t1 out_valid", out_valid, 4'b0001);
            check("t1 flit", out_flit[FW-1:0], pkt[i]);
        end
        in_valid = '0;
        cycle();
        check("t1 drained", out_valid, 4'b0000);

        // Route change mid-packet is ignored until the next head.
        drive(0, 2'b10, mk(1, 0, 14'h0101)); cycle();
        drive(0, 2'b01, mk(0, 0, 14'h0102)); cycle();
        check("t2 body on out1", out_valid, 4'b0100);
        drive(0, 2'b01, mk(0, 1, 14'h0103)); cycle();
        check("t2 tail on out1", out_valid, 4'b0100);
        drive(0, 2'b01, mk(1, 1, 14'h0104)); cycle();
        check("t2 new head on out0", out_valid, 4'b0001);

        // Single-flit packets leave the VC idle.
        drive(0, 2'b10, mk(1, 1, 14'h0201)); cycle();
        check("t3 single out1", out_valid, 4'b0100);
        drive(0, 2'b01, mk(1, 1, 14'h0202)); cycle();
        check("t3 next out0", out_valid, 4'b0001);

        // Route errors: empty select on head, body while idle.
        drive(0, 2'b00, mk(1, 0, 14'h0301));
        #1;
        check("t4 drop ready", in_ready[0], 1'b1);
        cycle();
        check("t4 error head", error, 2'b01);
        drive(0, 2'b01, mk(0, 0, 14'h0302)); cycle();
        check("t4 error body", error, 2'b01);
        check("t4 no out", out_valid, 4'b0000);
        in_valid = '0; cycle();
        check("t4 error clears", error, 2'b00);

        // Downstream stall holds the slice; release gives back-to-back flow.
        drive(0, 2'b01, mk(1, 0, 14'h0401)); cycle();
        out_ready = 4'b1110;
        drive(0, 2'b01, mk(0, 0, 14'h0402));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5 stall holds head", out_flit[FW-1:0], mk(1, 0, 14'h0401));
        end
        out_ready = '1;
        cycle();
        check("t5 body after release", out_flit[FW-1:0], mk(0, 0, 14'h0402));
        drive(0, 2'b01, mk(0, 1, 14'h0403)); cycle();
        check("t5 tail back-to-back", out_flit[FW-1:0], mk(0, 1, 14'h0403));
        in_valid = '0; cycle();

        // Reset while VC1 is mid-packet with a full slice.
        out_ready = '0;
        drive(1, 2'b01, mk(1, 0, 14'h0501)); cycle();
        check("t6 slice full", out_valid, 4'b0010);
        drive(1, 2'b01, mk(0, 0, 14'h0502)); cycle();
        rst = 1'b1;
        #1;
        reset_model();
        check("t6 rst out_valid", out_valid, 4'b0000);
        check("t6 rst in_ready", in_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        out_ready = '1;
        drive(1, 2'b01, mk(0, 0, 14'h0503)); cycle();
        check("t6 body dropped", error, 2'b10);
        check("t6 no out", out_valid, 4'b0000);
        in_valid = '0; cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!(in_valid != '0 && m_stalled)) begin
                if ($urandom_range(3) == 0) begin
                    in_valid = '0;
                end else begin
                    int v, k;
                    bit h, t;
                    v = $urandom_range(CH - 1);
                    k = $urandom_range(99);
                    if (m_busy[v]) begin
                        h = (k < 10); t = (k >= 65);
                    end else begin
                        h = (k < 80); t = (k >= 45 && k < 90);
                    end
                    in_valid = '0;
                    in_valid[v] = 1'b1;
                    in_flit = mk(h, t, 14'($urandom));
                    sel = (CH*E)'($urandom);
                end
            end
            out_ready = (E*CH)'($urandom | $urandom);
            out_avail = (E*CH)'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
